alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 239 +++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers, one result bit per cycle.
// Optional accumulate ops (MADD/MSUB families) are enabled by defining ALU_MULDIV_MADD_EN.
module alu_muldiv #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [2:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         flush,
   input  logic         mt_hi,
   input  logic         mt_lo,
   input  logic [N-1:0] wdata,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo,
   output logic         div_zero
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0]  LAST_CNT = CW'(N - 1);
   localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [N-1:0]   ONE_N    = {{(N-1){1'b0}}, 1'b1};
   localparam logic [2*N-1:0] ONE_2N   = {{(2*N-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic [2*N-1:0] work_q, work_d;
   logic [N-1:0]   opnd_q, opnd_d;
   logic           is_div_q, is_div_d;
   logic           neg_res_q, neg_res_d;
   logic           neg_rem_q, neg_rem_d;
   logic [N-1:0]   hi_q, hi_d;
   logic [N-1:0]   lo_q, lo_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           div_zero_q, div_zero_d;
`ifdef ALU_MULDIV_MADD_EN
   logic           acc_q, acc_d;
   logic           sub_q, sub_d;
`endif

   logic [N:0]     mul_sum_s;
   logic [N:0]     div_sh_s;
   logic [N:0]     div_diff_s;
   logic           div_ge_s;
   logic [2*N-1:0] step_s;
   logic [2*N-1:0] prod_s;
   logic [N-1:0]   quot_s;
   logic [N-1:0]   rem_s;
   logic [N-1:0]   res_hi_s;
   logic [N-1:0]   res_lo_s;
   logic           op_ok_s;
   logic           accept_s;
   logic           a_neg_s;
   logic           b_neg_s;
   logic [N-1:0]   a_mag_s;
   logic [N-1:0]   b_mag_s;

   // One shift-add or restoring-subtract step on the working register.
   always_comb begin
      mul_sum_s  = {1'b0, work_q[2*N-1:N]} + (work_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
      div_sh_s   = {work_q[2*N-1:N], work_q[N-1]};
      div_diff_s = div_sh_s - {1'b0, opnd_q};
      div_ge_s   = div_sh_s[N] | ~div_diff_s[N];
      if (is_div_q) begin
         if (div_ge_s) begin
            step_s = {div_diff_s[N-1:0], work_q[N-2:0], 1'b1};
         end else begin
            step_s = {div_sh_s[N-1:0], work_q[N-2:0], 1'b0};
         end
      end else begin
         step_s = {mul_sum_s, work_q[N-1:1]};
      end
   end

   // Sign correction and optional accumulation of the final step's result.
   always_comb begin
      prod_s = neg_res_q ? (~step_s + ONE_2N) : step_s;
      quot_s = step_s[N-1:0];
      rem_s  = step_s[2*N-1:N];
      if (is_div_q) begin
         // A zero divisor leaves the dividend magnitude as remainder; re-signing restores a.
         res_lo_s = div_zero_q ? {N{1'b1}} : (neg_res_q ? (~quot_s + ONE_N) : quot_s);
         res_hi_s = neg_rem_q ? (~rem_s + ONE_N) : rem_s;
      end else begin
`ifdef ALU_MULDIV_MADD_EN
         if (acc_q) begin
            if (sub_q) begin
               {res_hi_s, res_lo_s} = {hi_q, lo_q} - prod_s;
            end else begin
               {res_hi_s, res_lo_s} = {hi_q, lo_q} + prod_s;
            end
         end else begin
            {res_hi_s, res_lo_s} = prod_s;
         end
`else
         {res_hi_s, res_lo_s} = prod_s;
`endif
      end
   end

   // Operand decode for a new request.
   always_comb begin
`ifdef ALU_MULDIV_MADD_EN
      op_ok_s = 1'b1;
`else
      op_ok_s = ~op[2];
`endif
      accept_s = start & (state_q != S_CALC) & op_ok_s;
      a_neg_s  = ~op[0] & a[N-1];
      b_neg_s  = ~op[0] & b[N-1];
      a_mag_s  = a_neg_s ? (~a + ONE_N) : a;
      b_mag_s  = b_neg_s ? (~b + ONE_N) : b;
   end

   // Next-state and datapath control.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      work_d     = work_q;
      opnd_d     = opnd_q;
      is_div_d   = is_div_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;
`ifdef ALU_MULDIV_MADD_EN
      acc_d      = acc_q;
      sub_d      = sub_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept_s) begin
               state_d    = S_CALC;
               count_d    = {CW{1'b0}};
               is_div_d   = ~op[2] & op[1];
               neg_res_d  = a_neg_s ^ b_neg_s;
               neg_rem_d  = a_neg_s;
               div_zero_d = ~op[2] & op[1] & (b == {N{1'b0}});
`ifdef ALU_MULDIV_MADD_EN
               acc_d      = op[2];
               sub_d      = op[1];
`endif
               if (~op[2] & op[1]) begin
                  work_d = {{N{1'b0}}, a_mag_s};
                  opnd_d = b_mag_s;
               end else begin
                  work_d = {{N{1'b0}}, b_mag_s};
                  opnd_d = a_mag_s;
               end
            end else begin
               state_d = S_IDLE;
               if (!start) begin
                  hi_d = mt_hi ? wdata : hi_q;
                  lo_d = mt_lo ? wdata : lo_q;
               end else begin
                  hi_d = hi_q;
               end
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               work_d = step_s;
               if (count_q == LAST_CNT) begin
                  state_d = S_DONE;
                  hi_d    = res_hi_s;
                  lo_d    = res_lo_s;
               end else begin
                  count_d = count_q + CNT_ONE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d == S_CALC);
      done_d = (state_d == S_DONE);
   end

   // State and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         count_q    <= {CW{1'b0}};
         work_q     <= {(2*N){1'b0}};
         opnd_q     <= {N{1'b0}};
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         hi_q       <= {N{1'b0}};
         lo_q       <= {N{1'b0}};
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
`ifdef ALU_MULDIV_MADD_EN
         acc_q      <= 1'b0;
         sub_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         work_q     <= work_d;
         opnd_q     <= opnd_d;
         is_div_q   <= is_div_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
`ifdef ALU_MULDIV_MADD_EN
         acc_q      <= acc_d;
         sub_q      <= sub_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (N = 32).
module tb_alu_muldiv;
   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   op = 3'b000;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         flush = 1'b0;
   logic         mt_hi = 1'b0;
   logic         mt_lo = 1'b0;
   logic [N-1:0] wdata = '0;
   logic         busy;
   logic         done;
   logic [N-1:0] hi;
   logic [N-1:0] lo;
   logic         div_zero;

   int tests_run = 0;
   int tests_failed = 0;

   alu_muldiv #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .mt_hi(mt_hi), .mt_lo(mt_lo), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   // Issue one op at E0, then observe cycles 1..N+3 (optional flush / mt_lo / restart pulses).
   task automatic run_op(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                         input int flush_cyc, input int mt_cyc, input int restart_cyc,
                         output int done_cyc, output int busy_cnt, output int done_cnt);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1;
      start = 1'b0; op = ~o; a = ~x; b = ~y;
      done_cyc = 0; busy_cnt = 0; done_cnt = 0;
      for (int k = 1; k <= N + 3; k++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = k;
         end
         flush = (k == flush_cyc);
         mt_lo = (k == mt_cyc);
         wdata = 32'h0000_DEAD;
         start = (k == restart_cyc);
         if (k == restart_cyc) begin
            op = 3'b011; a = 32'd1; b = 32'd0;
         end
      end
      flush = 1'b0; mt_lo = 1'b0; start = 1'b0;
   endtask

   task automatic mt_write(input logic h, input logic l, input logic [N-1:0] d);
      @(negedge clk);
      mt_hi = h; mt_lo = l; wdata = d;
      @(negedge clk);
      mt_hi = 1'b0; mt_lo = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      tests_run++;
      if ({busy, done, div_zero} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b expected 000", {busy, done, div_zero});
      end
      tests_run++;
      if ({hi, lo} !== 64'h0) begin
         tests_failed++;
         $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_multu();
      int dc, bc, dn;
      run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, dc, bc, dn);
      tests_run++;
      if (dc !== 33) begin tests_failed++; $display("FAIL multu_latency: got %0d expected 33", dc); end
      tests_run++;
      if (bc !== 32) begin tests_failed++; $display("FAIL multu_busy_cycles: got %0d expected 32", bc); end
      tests_run++;
      if (dn !== 1) begin tests_failed++; $display("FAIL multu_done_pulse: got %0d expected 1", dn); end
      tests_run++;
      if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
         tests_failed++; $display("FAIL multu_result: got %h expected fffffffe00000001", {hi, lo});
      end
   endtask

   task automatic test_mult();
      int dc, bc, dn;
      run_op(3'b000, 32'hFFFF_FFFD, 32'd5, 0, 0, 0, dc, bc, dn);
      tests_run++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
         tests_failed++; $display("FAIL mult_neg_pos: got %h expected fffffffffffffff1", {hi, lo});
      end
      run_op(3'b000, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, dc, bc, dn);
      tests_run++;
      if ({hi, lo} !== 64'h4000_0000_0000_0000) begin
         tests_failed++; $display("FAIL mult_min_min: got %h expected 4000000000000000", {hi, lo});
      end
      run_op(3'b000, 32'd7, 32'hFFFF_FFFF, 0, 0, 0, dc, bc, dn);
      tests_run++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF9) begin
         tests_failed++; $display("FAIL mult_pos_neg: got %h expected fffffffffffffff9", {hi, lo});
      end
   endtask

   task automatic test_div();
      int dc, bc, dn;
      run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, dc, bc, dn);
      tests_run++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         tests_failed++; $display("FAIL div_m7_2: got %h expected fffffffffffffffd", {hi, lo});
      end
      tests_run++;
      if (dc !== 33) begin tests_failed++; $display("FAIL div_latency: got %0d expected 33", dc); end
      run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, dc, bc, dn);
      tests_run++;
      if ({hi, lo, div_zero} !== {64'h0000_0000_8000_0000, 1'b0}) begin
         tests_failed++; $display("FAIL div_min_m1: got %h/%b expected 0000000080000000/0", {hi, lo}, div_zero);
      end
      run_op(3'b011, 32'd100, 32'd7, 0, 0, 0, dc, bc, dn);
      tests_run++;
      if ({hi, lo} !== 64'h0000_0002_0000_000E) begin
         tests_failed++; $display("FAIL divu_100_7: got %h expected 000000020000000e", {hi, lo});
      end
      run_op(3'b010, 32'd7, 32'hFFFF_FFFE, 0, 0, 0, dc, bc, dn);
      tests_run++;
      if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin
         tests_failed++; $display("FAIL div_7_m2: got %h expected 00000001fffffffd", {hi, lo});
      end
      run_op(3'b011, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, dc, bc, dn);
      tests_run++;
      if ({hi, lo} !== 64'h0000_0000_FFFF_FFFF) begin
         tests_failed++; $display("FAIL divu_max_1: got %h expected 00000000ffffffff", {hi, lo});
      end
   endtask

   task automatic test_div_zero();
      int dc, bc, dn;
      run_op(3'b011, 32'h0000_1234, 32'd0, 0, 0, 0, dc, bc, dn);
      tests_run++;
      if ({hi, lo, div_zero} !== {64'h0000_1234_FFFF_FFFF, 1'b1}) begin
         tests_failed++; $display("FAIL divu_zero: got %h/%b expected 00001234ffffffff/1", {hi, lo}, div_zero);
      end
      tests_run++;
      if (dc !== 33) begin tests_failed++; $display("FAIL divzero_latency: got %0d expected 33", dc); end
      run_op(3'b010, 32'hFFFF_FFFB, 32'd0, 0, 0, 0, dc, bc, dn);
      tests_run++;
      if ({hi, lo, div_zero} !== {64'hFFFF_FFFB_FFFF_FFFF, 1'b1}) begin
         tests_failed++; $display("FAIL div_neg_zero: got %h/%b expected fffffffbffffffff/1", {hi, lo}, div_zero);
      end
      run_op(3'b000, 32'd2, 32'd3, 0, 0, 0, dc, bc, dn);
      tests_run++;
      if ({hi, lo, div_zero} !== {64'h6, 1'b0}) begin
         tests_failed++; $display("FAIL divzero_clear: got %h/%b expected 0000000000000006/0", {hi, lo}, div_zero);
      end
   endtask

   task automatic test_operand_latch();
      int dc, bc, dn;
      run_op(3'b001, 32'd6, 32'd7, 0, 8, 3, dc, bc, dn);
      tests_run++;
      if ({hi, lo} !== 64'd42) begin
         tests_failed++; $display("FAIL latch_result: got %h expected 000000000000002a", {hi, lo});
      end
      tests_run++;
      if ({dc, div_zero} !== {32'd33, 1'b0}) begin
         tests_failed++; $display("FAIL start_in_calc: got %0d/%b expected 33/0", dc, div_zero);
      end
   endtask

   task automatic test_flush();
      int dc, bc, dn;
      run_op(3'b000, 32'd5, 32'd5, 5, 0, 0, dc, bc, dn);
      tests_run++;
      if ({bc, dn} !== {32'd5, 32'd0}) begin
         tests_failed++; $display("FAIL flush_busy_done: got %0d/%0d expected 5/0", bc, dn);
      end
      tests_run++;
      if ({hi, lo} !== 64'd42) begin
         tests_failed++; $display("FAIL flush_hilo: got %h expected 000000000000002a", {hi, lo});
      end
   endtask

   task automatic test_madd();
      int dc, bc, dn;
      run_op(3'b011, 32'd9, 32'd0, 0, 0, 0, dc, bc, dn);
      mt_write(1'b1, 1'b0, 32'd0);
      mt_write(1'b0, 1'b1, 32'd10);
      tests_run++;
      if ({hi, lo} !== 64'h0000_0000_0000_000A) begin
         tests_failed++; $display("FAIL mt_write: got %h expected 000000000000000a", {hi, lo});
      end
      run_op(3'b110, 32'd3, 32'd4, 0, 0, 0, dc, bc, dn);
`ifdef ALU_MULDIV_MADD_EN
      tests_run++;
      if ({hi, lo, div_zero} !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b0}) begin
         tests_failed++; $display("FAIL msub: got %h/%b expected fffffffffffffffe/0", {hi, lo}, div_zero);
      end
      tests_run++;
      if (dc !== 33) begin tests_failed++; $display("FAIL msub_latency: got %0d expected 33", dc); end
      run_op(3'b101, 32'd1, 32'd5, 0, 0, 0, dc, bc, dn);
      tests_run++;
      if ({hi, lo} !== 64'd3) begin
         tests_failed++; $display("FAIL maddu_wrap: got %h expected 0000000000000003", {hi, lo});
      end
      run_op(3'b100, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, dc, bc, dn);
      tests_run++;
      if ({hi, lo} !== 64'd1) begin
         tests_failed++; $display("FAIL madd_signed: got %h expected 0000000000000001", {hi, lo});
      end
`else
      tests_run++;
      if ({bc, dn} !== {32'd0, 32'd0}) begin
         tests_failed++; $display("FAIL madd_disabled_busy: got %0d/%0d expected 0/0", bc, dn);
      end
      tests_run++;
      if ({hi, lo, div_zero} !== {64'h0000_0000_0000_000A, 1'b1}) begin
         tests_failed++; $display("FAIL madd_disabled_state: got %h/%b expected 000000000000000a/1", {hi, lo}, div_zero);
      end
`endif
   endtask

   task automatic test_back_to_back();
      int d1, d2;
      logic [2*N-1:0] r1;
      logic b2;
      d1 = 0; d2 = 0; r1 = '0; b2 = 1'b0;
      @(negedge clk);
      start = 1'b1; op = 3'b001; a = 32'd6; b = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 1; k <= 2 * N + 5; k++) begin
         @(negedge clk);
         if (done) begin
            if (d1 == 0) d1 = k;
            else if (d2 == 0) d2 = k;
         end
         if (k == N + 1) r1 = {hi, lo};
         if (k == N + 2) b2 = busy;
         start = (k == N + 1);
         if (k == N + 1) begin
            op = 3'b001; a = 32'd3; b = 32'd3;
         end
      end
      start = 1'b0;
      tests_run++;
      if ({d1, d2} !== {32'd33, 32'd66}) begin
         tests_failed++; $display("FAIL b2b_done_cycles: got %0d/%0d expected 33/66", d1, d2);
      end
      tests_run++;
      if ({r1, b2} !== {64'd42, 1'b1}) begin
         tests_failed++; $display("FAIL b2b_first: got %h/%b expected 000000000000002a/1", r1, b2);
      end
      tests_run++;
      if ({hi, lo} !== 64'd9) begin
         tests_failed++; $display("FAIL b2b_second: got %h expected 0000000000000009", {hi, lo});
      end
   endtask

   task automatic test_reset_mid();
      logic busy_pre;
      int dn;
      busy_pre = 1'b0; dn = 0;
      @(negedge clk);
      start = 1'b1; op = 3'b011; a = 32'd5; b = 32'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         busy_pre = busy;
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (busy_pre !== 1'b1) begin
         tests_failed++; $display("FAIL rst_mid_pre_busy: got %b expected 1", busy_pre);
      end
      tests_run++;
      if ({busy, done, div_zero, hi, lo} !== {3'b000, 64'h0}) begin
         tests_failed++; $display("FAIL rst_mid_outputs: got %b/%h expected 000/0", {busy, done, div_zero}, {hi, lo});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < N + 5; k++) begin
         @(negedge clk);
         if (done || busy) dn++;
      end
      tests_run++;
      if (dn !== 0) begin
         tests_failed++; $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", dn);
      end
   endtask

   initial begin
      test_reset();
      test_multu();
      test_mult();
      test_div();
      test_div_zero();
      test_operand_latch();
      test_flush();
      test_madd();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
